// File: rtl/password_check.sv
// Four-digit keypad lock controller: buffers BCD digits, checks them against CLAVE,
// and drives the LCD message select, lock actuator and lockout indication.
module password_check #(
    parameter logic [15:0] CLAVE       = 16'h1234,
    parameter int unsigned MAX_FAIL    = 3,
    parameter int unsigned MSG_CYCLES  = 100_000_000,
    parameter int unsigned OPEN_CYCLES = 250_000_000,
    parameter int unsigned LOCK_CYCLES = 500_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [1:0] sel_msg,
    output logic       message_change,
    output logic [2:0] digit_count,
    output logic       unlocked,
    output logic       locked_out
);

    typedef enum logic [2:0] {
        ST_ENTRY,
        ST_CHECK,
        ST_OPEN,
        ST_FAIL,
        ST_LOCKED
    } state_t;

    localparam logic [1:0]  MSG_ENTRY  = 2'b01;
    localparam logic [1:0]  MSG_OPEN   = 2'b10;
    localparam logic [1:0]  MSG_WRONG  = 2'b11;
    localparam logic [1:0]  MSG_LOCKED = 2'b00;
    localparam logic [3:0]  KEY_CLEAR  = 4'hA;
    localparam logic [3:0]  KEY_ENTER  = 4'hB;
    localparam logic [2:0]  FAIL_LIMIT = 3'(MAX_FAIL);
    localparam logic [31:0] OPEN_LOAD  = 32'(OPEN_CYCLES - 1);
    localparam logic [31:0] MSG_LOAD   = 32'(MSG_CYCLES - 1);
    localparam logic [31:0] LOCK_LOAD  = 32'(LOCK_CYCLES - 1);

    state_t      state;
    logic [15:0] code_buf;
    logic [2:0]  fail_cnt;
    logic [31:0] timer;
    logic        key_valid_q;
    logic [3:0]  key_code_q;
    logic [2:0]  fail_next;
    logic        leave;

    // Keys are registered first, so the FSM acts on them one edge after sampling.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
        end else begin
            key_valid_q <= key_valid;
            key_code_q  <= key_code;
        end
    end

    always_comb begin
        fail_next = (fail_cnt == 3'd7) ? 3'd7 : fail_cnt + 3'd1;
        leave     = (timer == '0) ||
                    ((state == ST_OPEN) && key_valid_q && (key_code_q == KEY_CLEAR));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_ENTRY;
            code_buf       <= '0;
            digit_count    <= '0;
            fail_cnt       <= '0;
            timer          <= '0;
            sel_msg        <= MSG_ENTRY;
            message_change <= 1'b0;
            unlocked       <= 1'b0;
            locked_out     <= 1'b0;
        end else begin
            message_change <= 1'b0;
            case (state)
                ST_ENTRY: begin
                    if (key_valid_q) begin
                        if (key_code_q <= 4'd9) begin
                            if (digit_count != 3'd4) begin
                                code_buf    <= {code_buf[11:0], key_code_q};
                                digit_count <= digit_count + 3'd1;
                            end
                        end else if (key_code_q == KEY_CLEAR) begin
                            code_buf    <= '0;
                            digit_count <= '0;
                        end else if ((key_code_q == KEY_ENTER) && (digit_count == 3'd4)) begin
                            state <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    message_change <= 1'b1;
                    if (code_buf == CLAVE) begin
                        state    <= ST_OPEN;
                        fail_cnt <= '0;
                        timer    <= OPEN_LOAD;
                        sel_msg  <= MSG_OPEN;
                        unlocked <= 1'b1;
                    end else begin
                        fail_cnt <= fail_next;
                        if (fail_next == FAIL_LIMIT) begin
                            state      <= ST_LOCKED;
                            timer      <= LOCK_LOAD;
                            sel_msg    <= MSG_LOCKED;
                            locked_out <= 1'b1;
                        end else begin
                            state   <= ST_FAIL;
                            timer   <= MSG_LOAD;
                            sel_msg <= MSG_WRONG;
                        end
                    end
                end
                ST_OPEN, ST_FAIL, ST_LOCKED: begin
                    if (leave) begin
                        state          <= ST_ENTRY;
                        timer          <= '0;
                        sel_msg        <= MSG_ENTRY;
                        message_change <= 1'b1;
                        code_buf       <= '0;
                        digit_count    <= '0;
                        unlocked       <= 1'b0;
                        locked_out     <= 1'b0;
                        if (state == ST_LOCKED) begin
                            fail_cnt <= '0;
                        end
                    end else begin
                        timer <= timer - 32'd1;
                    end
                end
                default: state <= ST_ENTRY;
            endcase
        end
    end

endmodule

// File: tb/tb_password_check.sv
// Bench for password_check: directed scenarios plus random key traffic, checked every
// cycle against a transaction-level model of the lock (digit queue, hold-time countdown).
module tb_password_check;

    localparam int MSG_N  = 8;
    localparam int OPEN_N = 20;
    localparam int LOCK_N = 16;
    localparam int MAXF   = 3;
    localparam logic [15:0] PASS = 16'h1234;

    localparam int M_ENTRY = 0, M_CHECK = 1, M_OPEN = 2, M_WRONG = 3, M_LOCK = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_code;
    logic [1:0] sel_msg;
    logic       message_change;
    logic [2:0] digit_count;
    logic       unlocked;
    logic       locked_out;

    int total = 0;
    int bad   = 0;

    int m_mode;
    int m_left;
    int m_digits[$];
    int m_fails;
    bit m_pulse;
    bit m_kv;
    int m_kc;

    password_check #(
        .CLAVE(PASS),
        .MAX_FAIL(MAXF),
        .MSG_CYCLES(MSG_N),
        .OPEN_CYCLES(OPEN_N),
        .LOCK_CYCLES(LOCK_N)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key_valid(key_valid),
        .key_code(key_code),
        .sel_msg(sel_msg),
        .message_change(message_change),
        .digit_count(digit_count),
        .unlocked(unlocked),
        .locked_out(locked_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int entered_value();
        int v = 0;
        foreach (m_digits[i]) v = v * 16 + m_digits[i];
        return v;
    endfunction

    function automatic logic [1:0] shown_msg();
        case (m_mode)
            M_OPEN:  return 2'b10;
            M_WRONG: return 2'b11;
            M_LOCK:  return 2'b00;
            default: return 2'b01;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = M_ENTRY;
        m_left = 0;
        m_digits.delete();
        m_fails = 0;
        m_pulse = 0;
        m_kv = 0;
        m_kc = 0;
    endtask

    // One clock edge of the lock as seen by a user: the previous cycle's key takes effect now.
    task automatic model_step(input bit v, input int c);
        m_pulse = 0;
        case (m_mode)
            M_ENTRY: if (m_kv) begin
                if (m_kc <= 9 && m_digits.size() < 4) m_digits.push_back(m_kc);
                else if (m_kc == 10) m_digits.delete();
                else if (m_kc == 11 && m_digits.size() == 4) m_mode = M_CHECK;
            end
            M_CHECK: begin
                m_pulse = 1;
                if (entered_value() == int'(PASS)) begin
                    m_mode = M_OPEN; m_left = OPEN_N; m_fails = 0;
                end else begin
                    m_fails = (m_fails + 1 > 7) ? 7 : m_fails + 1;
                    if (m_fails == MAXF) begin m_mode = M_LOCK; m_left = LOCK_N; end
                    else begin m_mode = M_WRONG; m_left = MSG_N; end
                end
            end
            default: begin
                m_left--;
                if (m_left == 0 || (m_mode == M_OPEN && m_kv && m_kc == 10)) begin
                    if (m_mode == M_LOCK) m_fails = 0;
                    m_mode = M_ENTRY;
                    m_digits.delete();
                    m_pulse = 1;
                end
            end
        endcase
        m_kv = v;
        m_kc = c;
    endtask

    task automatic check_all();
        chk("sel_msg", 32'(sel_msg), 32'(shown_msg()));
        chk("message_change", 32'(message_change), 32'(m_pulse));
        chk("digit_count", 32'(digit_count), 32'(m_digits.size()));
        chk("unlocked", 32'(unlocked), 32'(m_mode == M_OPEN));
        chk("locked_out", 32'(locked_out), 32'(m_mode == M_LOCK));
        chk("fail_cnt", 32'(dut.fail_cnt), 32'(m_fails));
        chk("code_buf", 32'(dut.code_buf), 32'(entered_value()));
    endtask

    task automatic cycle(input logic v, input logic [3:0] c);
        key_valid = v;
        key_code  = c;
        @(posedge clk);
        model_step(v, int'(c));
        @(negedge clk);
        check_all();
    endtask

    task automatic press(input logic [3:0] c);
        cycle(1'b1, c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'h0);
    endtask

    task automatic enter_code(input logic [15:0] code);
        for (int i = 3; i >= 0; i--) press(code[i*4 +: 4]);
        press(4'hB);
    endtask

    function automatic logic [15:0] wrong_code();
        logic [15:0] w;
        do begin
            for (int i = 0; i < 4; i++) w[i*4 +: 4] = 4'($urandom_range(0, 9));
        end while (w == PASS);
        return w;
    endfunction

    initial begin
        reset = 1'b0;
        key_valid = 1'b0;
        key_code = 4'h0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        reset = 1'b1;
        idle(2);

        // correct code, open for the full hold time
        enter_code(PASS);
        idle(OPEN_N + 5);

        // wrong code, keys ignored during the message
        enter_code(wrong_code());
        idle(1);
        for (int i = 0; i < MSG_N; i++) press(4'($urandom_range(0, 15)));
        idle(4);

        // second wrong, then correct, early close with '*', then wrong shows 11 not 00
        enter_code(wrong_code());
        idle(MSG_N + 4);
        enter_code(PASS);
        idle(5);
        press(4'hA);
        idle(2);
        enter_code(wrong_code());
        idle(MSG_N + 4);

        // two more wrong entries reach the lockout, then a correct code opens
        enter_code(wrong_code());
        idle(MSG_N + 4);
        enter_code(wrong_code());
        idle(4);
        for (int i = 0; i < 6; i++) press(4'($urandom_range(0, 15)));
        idle(LOCK_N);
        enter_code(PASS);
        idle(6);

        // asynchronous reset in the middle of the open state
        reset = 1'b0;
        #1;
        chk("rst_sel_msg", 32'(sel_msg), 32'h1);
        chk("rst_message_change", 32'(message_change), 32'h0);
        chk("rst_digit_count", 32'(digit_count), 32'h0);
        chk("rst_unlocked", 32'(unlocked), 32'h0);
        chk("rst_locked_out", 32'(locked_out), 32'h0);
        model_reset();
        @(negedge clk);
        check_all();
        reset = 1'b1;
        idle(3);

        // digit overflow, clear, short enter
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h9);
        idle(2);
        press(4'hA); press(4'hB);
        idle(2);
        press(4'h1); press(4'h2); press(4'hB);
        idle(3);
        press(4'hA);
        press(4'hC); press(4'hF);
        idle(2);

        // random traffic
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0: enter_code(PASS);
                1: enter_code(wrong_code());
                2: press(4'($urandom_range(0, 15)));
                3: idle($urandom_range(1, 25));
                default: press(4'hA);
            endcase
        end
        idle(LOCK_N + 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/password_check.md
PASSWORD_CHECK -- requirements
Module: password_check

Interface
REQ-001 SHALL have parameter CLAVE, default 16'h1234, four BCD digits of the valid password, most significant digit entered first.
REQ-002 SHALL have parameter MAX_FAIL, default 3, consecutive wrong attempts that trigger lockout (range 1..7).
REQ-003 SHALL have parameter MSG_CYCLES, default 100_000_000, hold time in clk cycles of the error message (2 s at 50 MHz).
REQ-004 SHALL have parameter OPEN_CYCLES, default 250_000_000, hold time in clk cycles of the open state.
REQ-005 SHALL have parameter LOCK_CYCLES, default 500_000_000, lockout duration in clk cycles.
REQ-006 SHALL have port clk, input, 1 bit: 50 MHz system clock, all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port key_valid, input, 1 bit: one-cycle pulse per debounced keypress from the keypad scanner.
REQ-009 SHALL have port key_code, input, 4 bits: key code, valid when key_valid=1; 0x0-0x9 are digits, 0xA is clear ('*'), 0xB is enter ('#'), and 0xC-0xF are ignored.
REQ-010 SHALL have port sel_msg, output, 2 bits: LCD message select; 01 = INGRESA CLAVE, 10 = ABIERTO, 11 = CLAVE INCORRECTA, 00 = BLOQUEADO.
REQ-011 SHALL have port message_change, output, 1 bit: one-cycle pulse, asserted in the same cycle sel_msg takes a new value.
REQ-012 SHALL have port digit_count, output, 3 bits: number of digits currently buffered (0-4).
REQ-013 SHALL have port unlocked, output, 1 bit: high while in OPEN, drives the lock actuator.
REQ-014 SHALL have port locked_out, output, 1 bit: high while in LOCKED.

Function
REQ-015 SHALL implement FSM states ENTRY, CHECK, OPEN, FAIL and LOCKED; all outputs SHALL be registered.
REQ-016 In ENTRY, a digit key with digit_count<4 SHALL shift the digit into a 16-bit buffer (buf <= {buf[11:0], key_code}) and increment digit_count on the next edge.
REQ-017 In ENTRY, a digit key with digit_count=4 SHALL be ignored, with no overwrite and no wrap-around.
REQ-018 In ENTRY, clear SHALL zero the buffer and digit_count; clear with digit_count=0 SHALL be a no-op.
REQ-019 In ENTRY, enter with digit_count=4 SHALL move the FSM to CHECK; enter with digit_count<4 SHALL be ignored.
REQ-020 In ENTRY, codes 0xC-0xF SHALL be ignored in every state.
REQ-021 CHECK SHALL last exactly one cycle. On buf==CLAVE it SHALL go to OPEN, clear the fail counter and load the timer with OPEN_CYCLES-1. On mismatch it SHALL increment the fail counter and go to LOCKED (timer=LOCK_CYCLES-1) if the new count equals MAX_FAIL, otherwise to FAIL (timer=MSG_CYCLES-1).
REQ-022 Latency: with enter sampled at edge n, CHECK is active after edge n+1, and sel_msg/message_change update after edge n+2.
REQ-023 In OPEN, FAIL and LOCKED, a down-counter SHALL decrement each cycle; when the counter is 0, the next edge SHALL go to ENTRY, set sel_msg=01, pulse message_change, and clear the buffer and digit_count.
REQ-024 In OPEN, clear SHALL return to ENTRY immediately, with the same actions as timeout.
REQ-025 In FAIL and LOCKED, all keys SHALL be ignored.
REQ-026 Exit from LOCKED SHALL also clear the fail counter.
REQ-027 The fail counter SHALL be 3 bits and saturate at 7; it SHALL be cleared only by a correct password, LOCKED exit or reset.
REQ-028 The timer SHALL be 32 bits wide.
REQ-029 message_change SHALL pulse exactly once per state entry into OPEN, FAIL, LOCKED or ENTRY-from-timeout/clear, and never otherwise.
REQ-030 A key_valid pulse arriving in the same cycle as a timer expiry SHALL be ignored.
REQ-031 Back-to-back key_valid pulses on consecutive cycles SHALL each be processed.

Reset
REQ-032 While reset=0, asynchronously: state=ENTRY, buffer=0, digit_count=0, fail counter=0, timer=0, sel_msg=01, message_change=0, unlocked=0, locked_out=0.
REQ-033 Reset asserted mid-operation (any state, including OPEN) SHALL abort it with no message_change pulse; operation SHALL resume on the first edge after release.

Verification (MSG_CYCLES=8, OPEN_CYCLES=20, LOCK_CYCLES=16, MAX_FAIL=3)
REQ-034 Keys 1,2,3,4,# -> sel_msg=10 and one message_change pulse 2 cycles after #, unlocked=1 for 20 cycles, then sel_msg=01 with a pulse and digit_count=0.
REQ-035 Keys 1,2,3,5,# -> sel_msg=11 and one pulse; keys during the next 8 cycles are ignored; then sel_msg=01 and the fail counter reads 1.
REQ-036 Three wrong entries in a row -> the third yields sel_msg=00 and locked_out=1 for 16 cycles, then sel_msg=01; a subsequent 1,2,3,4,# opens.
REQ-037 Keys 1,2,3,4,9 -> digit_count stays 4 and buffer=0x1234; then *,# -> digit_count=0 and no state change; then 1,2,# -> ignored.
REQ-038 Reset pulse while in OPEN -> all outputs at reset values immediately, with no message_change pulse.
REQ-039 Two wrong entries, then a correct one, then one wrong -> sel_msg=11, not 00 (fail counter cleared by the correct entry).
